sift_sequencer: RTL
===================

# sift_sequencer

Top-level run controller for the SIFT pipeline. It starts the four processing stages in order: pyramid build, gradient pyramid, keypoint detection, descriptor generation. It waits for each stage's one-cycle done pulse and drives the shared-memory ownership select, so exactly one stage owns the pyramid/keypoint BRAM ports at a time. A per-stage watchdog and the stages' error flags drive a sticky fault state, so a hung stage (e.g. the descriptor generator never reaching FINISH) is reported instead of stalling silently.

## Interface
- TIMEOUT_CYCLES, default 2**20: maximum cycles a stage may stay active, counted from its start cycle.
- RUN_CNT_WIDTH, default 32: width of the run-length counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_in  in  1  synchronous, active-high reset.
- start  in  1  request a run; level or pulse, sampled as described below.
- abort  in  1  return to IDLE immediately.
- stage_start  out  4  one-hot, single-cycle start pulse. bit0 pyramid, bit1 gradient, bit2 keypoints, bit3 descriptors.
- stage_done  in  4  single-cycle done pulses, same bit order.
- stage_error  in  4  level error flags, same bit order.
- bram_owner  out  2  index of the stage owning the shared BRAM ports.
- busy  out  1  high in any stage state.
- sift_done  out  1  one-cycle pulse on successful completion.
- fault  out  1  sticky fault flag.
- fault_code  out  3  bit2 = 1 for timeout, 0 for error; bits1:0 = faulting stage index.
- state_num  out  3  IDLE=0, PYR=1, GRAD=2, KEYS=3, DESC=4, DONE=5, FAULT=6.
- run_cycles  out  RUN_CNT_WIDTH  cycles spent in stage states during the last run.

## Operation
- States: IDLE, PYR, GRAD, KEYS, DESC, DONE, FAULT. Stage index s = 0..3 maps to PYR..DESC.
- IDLE:
  - start=1 → next cycle enter PYR.
  - On acceptance, run_cycles clears to 0, and fault and fault_code clear.
- Entering stage s:
  - stage_start[s]=1 for exactly the entry cycle; all other bits 0.
  - Watchdog wd resets to 0 in the entry cycle and increments by 1 each following cycle.
- Per-cycle evaluation in stage s, in priority order:
  1. abort → IDLE.
  2. stage_error[s]=1 → FAULT, fault_code={0,s}.
  3. Accepted done, i.e. stage_done[s]=1 and not the entry cycle → next stage; from DESC → DONE.
  4. wd==TIMEOUT_CYCLES-1 → FAULT, fault_code={1,s}.
  5. Otherwise stay.
- Masked inputs:
  - stage_done is ignored in the entry cycle (stale-pulse guard).
  - stage_done and stage_error bits of non-active stages are always ignored.
- DONE: sift_done=1 for this single cycle, then IDLE unconditionally; start in this cycle is ignored.
- FAULT:
  - fault=1 and fault_code hold.
  - start=1 → clears fault and begins a new run (enter PYR next cycle, same as IDLE acceptance).
  - abort → IDLE with fault cleared.
- start is ignored in stage states and in DONE.
- bram_owner = s in stage states, 0 in IDLE, DONE and FAULT. It is registered and changes in the same cycle as the state.
- run_cycles increments once per cycle in any stage state and saturates at all-ones. It holds in DONE, FAULT and IDLE, and after abort.
- Reset values: state IDLE, stage_start 0, bram_owner 0, busy 0, sift_done 0, fault 0, fault_code 0, state_num 0, run_cycles 0, wd 0.

## Timing
- All outputs are registered.
- Latency:
  - start accepted at cycle N → stage_start[0] and state PYR at N+1.
  - Done accepted at cycle M → next stage_start at M+1.
  - DESC done at M → sift_done at M+1, IDLE at M+2.
- Maximum stage residency is TIMEOUT_CYCLES cycles.
  - A done accepted in the cycle where wd==TIMEOUT_CYCLES-1 wins over the timeout.
  - Otherwise FAULT is entered the next cycle.
- Error and done in the same cycle → FAULT.
- Abort and error in the same cycle → IDLE with fault=0.
- rst_in mid-run → all reset values next cycle; no sift_done or stage_start pulse is emitted.
- wd width is $clog2(TIMEOUT_CYCLES). The comparison is exact-equality against TIMEOUT_CYCLES-1.

## Test plan
All scenarios use TIMEOUT_CYCLES=16.
- Nominal run: start at N; each stage_done[s] arrives 3 cycles after stage_start[s]. Required: stage_start pulses at N+1, N+5, N+9, N+13; bram_owner 0,1,2,3 across those windows; sift_done at N+17; run_cycles=16; IDLE at N+18.
- Timeout: no done from KEYS. Required: FAULT exactly 16 cycles after stage_start[2]; fault_code=3'b110; fault stays high; stage_start stays 0.
- Error priority: stage_error[1] and stage_done[1] both high 2 cycles into GRAD. Required: FAULT, fault_code=3'b001, no stage_start[2].
- Stale and foreign inputs:
  - stage_done[0] in the PYR entry cycle → ignored; stage remains PYR.
  - stage_done[3] during PYR → ignored.
  - start asserted during GRAD → ignored.
- Abort mid-DESC at wd=5: IDLE next cycle, busy=0, sift_done never pulses, run_cycles holds.
- Restart from FAULT: start in FAULT → fault and fault_code clear; stage_start[0] the next cycle; run_cycles restarts from 0.
- Reset mid-run: rst_in held for one cycle in DESC → all outputs at reset values the following cycle.

Source files
------------

// File: rtl/sift_sequencer.sv
// sift_sequencer: runs the four SIFT stages in order with per-stage watchdog and sticky fault reporting
module sift_sequencer #(
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int RUN_CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  input  logic                     abort,
  output logic [3:0]               stage_start,
  input  logic [3:0]               stage_done,
  input  logic [3:0]               stage_error,
  output logic [1:0]               bram_owner,
  output logic                     busy,
  output logic                     sift_done,
  output logic                     fault,
  output logic [2:0]               fault_code,
  output logic [2:0]               state_num,
  output logic [RUN_CNT_WIDTH-1:0] run_cycles
);
  localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, PYR, GRAD, KEYS, DESC, DONE, FAULT} state_t;
  state_t          state, nxt;
  logic [WD_W-1:0] wd;
  logic [1:0]      s, nxt_s;
  logic [2:0]      code_n;
  logic            in_stage, nxt_stage, entry, timeout, accept;
  assign s         = 2'(state - PYR);
  assign nxt_s     = 2'(nxt - PYR);
  assign in_stage  = state inside {PYR, GRAD, KEYS, DESC};
  assign nxt_stage = nxt inside {PYR, GRAD, KEYS, DESC};
  // a nonzero stage_start register marks the entry cycle of the current stage
  assign entry     = |stage_start;
  assign timeout   = wd == WD_W'(TIMEOUT_CYCLES - 1);
  assign accept    = nxt == PYR && state != PYR;
  assign state_num = state;
  always_comb begin
    nxt    = state;
    code_n = fault_code;
    if (state == IDLE) nxt = start && !abort ? PYR : IDLE;
    else if (state == DONE) nxt = IDLE;
    else if (state == FAULT) nxt = abort ? IDLE : start ? PYR : FAULT;
    else if (abort) nxt = IDLE;
    else if (stage_error[s]) begin
      nxt    = FAULT;
      code_n = {1'b0, s};
    end else if (stage_done[s] && !entry) nxt = state_t'(state + 3'd1);
    else if (timeout) begin
      nxt    = FAULT;
      code_n = {1'b1, s};
    end
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state       <= IDLE;
      stage_start <= '0;
      bram_owner  <= '0;
      busy        <= 1'b0;
      sift_done   <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      run_cycles  <= '0;
      wd          <= '0;
    end else begin
      state       <= nxt;
      stage_start <= nxt_stage && nxt != state ? 4'b0001 << nxt_s : 4'b0000;
      bram_owner  <= nxt_stage ? nxt_s : 2'd0;
      busy        <= nxt_stage;
      sift_done   <= nxt == DONE;
      fault       <= nxt == FAULT;
      fault_code  <= nxt == FAULT ? code_n : 3'd0;
      wd          <= in_stage && nxt == state ? wd + WD_W'(1) : '0;
      run_cycles  <= accept ? '0 : in_stage && !(&run_cycles) ? run_cycles + RUN_CNT_WIDTH'(1) : run_cycles;
    end
  end
endmodule
